// File: rtl/exp8_arbitro_memoria_pkg.sv
// Shared definitions for the RAM arbiter between the game logic and the aux (debug/dump) port.
package exp8_arbitro_memoria_pkg;

  localparam int LARGURA_END          = 4;
  localparam int LARGURA_DADO         = 4;
  localparam int LARGURA_CNT          = 3;
  localparam int LIMITE_ESPERA_PADRAO = 7;

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    ACESSO_JOGO  = 3'd1,
    ACESSO_AUX   = 3'd2,
    LEITURA_JOGO = 3'd3,
    LEITURA_AUX  = 3'd4
  } estado_t;

endpackage

// File: rtl/exp8_contador_espera.sv
// Saturating starvation counter: counts arbitrations lost by aux, clear has priority over enable.
module exp8_contador_espera
  import exp8_arbitro_memoria_pkg::*;
#(
  parameter int LIMITE  = LIMITE_ESPERA_PADRAO,
  parameter int LARGURA = LARGURA_CNT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               limpa_i,
  input  logic               habilita_i,
  output logic [LARGURA-1:0] cnt_o
);

  localparam logic [LARGURA-1:0] LIMITE_V = LARGURA'(LIMITE);

  logic [LARGURA-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (limpa_i) begin
      cnt_d = '0;
    end else if (habilita_i && (cnt_q != LIMITE_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exp8_arbitro_memoria.sv
// Arbiter granting a synchronous-read RAM to the game port or the read-only aux port,
// with aux starvation protection after LIMITE_ESPERA consecutive lost ties.
module exp8_arbitro_memoria
  import exp8_arbitro_memoria_pkg::*;
#(
  parameter int LIMITE_ESPERA = LIMITE_ESPERA_PADRAO
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_jogo,
  input  logic                    we_jogo,
  input  logic [LARGURA_END-1:0]  end_jogo,
  input  logic [LARGURA_DADO-1:0] dado_jogo,
  input  logic                    req_aux,
  input  logic [LARGURA_END-1:0]  end_aux,
  input  logic                    bloqueia_aux,
  input  logic [LARGURA_DADO-1:0] mem_q,
  output logic                    mem_we,
  output logic [LARGURA_END-1:0]  mem_end,
  output logic [LARGURA_DADO-1:0] mem_d,
  output logic                    gnt_jogo,
  output logic                    gnt_aux,
  output logic                    valido_jogo,
  output logic                    valido_aux,
  output logic [LARGURA_DADO-1:0] q_leitura,
  output logic [2:0]              db_estado
);

  localparam logic [LARGURA_CNT-1:0] LIMITE_CNT = LARGURA_CNT'(LIMITE_ESPERA);

  estado_t                 estado_q, estado_d;
  logic [LARGURA_END-1:0]  end_q, end_d;
  logic [LARGURA_DADO-1:0] dado_q, dado_d;
  logic [LARGURA_DADO-1:0] leitura_q, leitura_d;
  logic                    we_q, we_d;
  logic                    val_jogo_q, val_jogo_d;
  logic                    val_aux_q, val_aux_d;
  logic [LARGURA_CNT-1:0]  cnt_espera;
  logic                    aux_apto, vence_aux, vence_jogo;
  logic                    limpa_cnt, hab_cnt;

  // Winner selection is only meaningful in OCIOSO; both flags are low elsewhere.
  assign aux_apto   = req_aux && !bloqueia_aux;
  assign vence_aux  = (estado_q == OCIOSO) && aux_apto &&
                      ((cnt_espera == LIMITE_CNT) || !req_jogo);
  assign vence_jogo = (estado_q == OCIOSO) && req_jogo && !vence_aux;

  assign limpa_cnt  = !req_aux || vence_aux;
  assign hab_cnt    = vence_jogo && aux_apto;

  exp8_contador_espera #(
    .LIMITE  (LIMITE_ESPERA),
    .LARGURA (LARGURA_CNT)
  ) u_contador_espera (
    .clock      (clock),
    .reset      (reset),
    .limpa_i    (limpa_cnt),
    .habilita_i (hab_cnt),
    .cnt_o      (cnt_espera)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO: begin
        if (vence_aux) begin
          estado_d = ACESSO_AUX;
        end else if (vence_jogo) begin
          estado_d = ACESSO_JOGO;
        end
      end
      ACESSO_JOGO:  estado_d = we_q ? OCIOSO : LEITURA_JOGO;
      ACESSO_AUX:   estado_d = LEITURA_AUX;
      LEITURA_JOGO: estado_d = OCIOSO;
      LEITURA_AUX:  estado_d = OCIOSO;
      default:      estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    gnt_jogo  = (estado_q == ACESSO_JOGO);
    gnt_aux   = (estado_q == ACESSO_AUX);
    mem_we    = (estado_q == ACESSO_JOGO) && we_q;
    db_estado = estado_q;
  end

  // Aux never writes, so its access leaves the data latch untouched.
  always_comb begin
    end_d      = end_q;
    dado_d     = dado_q;
    we_d       = we_q;
    leitura_d  = leitura_q;
    val_jogo_d = 1'b0;
    val_aux_d  = 1'b0;
    if (vence_aux) begin
      end_d = end_aux;
      we_d  = 1'b0;
    end else if (vence_jogo) begin
      end_d  = end_jogo;
      dado_d = dado_jogo;
      we_d   = we_jogo;
    end
    if (estado_q == LEITURA_JOGO) begin
      leitura_d  = mem_q;
      val_jogo_d = 1'b1;
    end
    if (estado_q == LEITURA_AUX) begin
      leitura_d = mem_q;
      val_aux_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      end_q      <= '0;
      dado_q     <= '0;
      we_q       <= 1'b0;
      leitura_q  <= '0;
      val_jogo_q <= 1'b0;
      val_aux_q  <= 1'b0;
    end else begin
      end_q      <= end_d;
      dado_q     <= dado_d;
      we_q       <= we_d;
      leitura_q  <= leitura_d;
      val_jogo_q <= val_jogo_d;
      val_aux_q  <= val_aux_d;
    end
  end

  assign mem_end     = end_q;
  assign mem_d       = dado_q;
  assign q_leitura   = leitura_q;
  assign valido_jogo = val_jogo_q;
  assign valido_aux  = val_aux_q;

endmodule

// File: tb/tb_exp8_arbitro_memoria.sv
// Bench for exp8_arbitro_memoria: directed scenarios plus randomized traffic against a
// transaction-schedule model of the arbiter and a behavioural synchronous RAM.
module tb_exp8_arbitro_memoria;

  localparam int LIM = 7;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_jogo, we_jogo, req_aux, bloqueia_aux;
  logic [3:0] end_jogo, dado_jogo, end_aux;
  logic [3:0] mem_q;
  logic       mem_we, gnt_jogo, gnt_aux, valido_jogo, valido_aux;
  logic [3:0] mem_end, mem_d, q_leitura;
  logic [2:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  exp8_arbitro_memoria #(.LIMITE_ESPERA(LIM)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_jogo     (req_jogo),
    .we_jogo      (we_jogo),
    .end_jogo     (end_jogo),
    .dado_jogo    (dado_jogo),
    .req_aux      (req_aux),
    .end_aux      (end_aux),
    .bloqueia_aux (bloqueia_aux),
    .mem_q        (mem_q),
    .mem_we       (mem_we),
    .mem_end      (mem_end),
    .mem_d        (mem_d),
    .gnt_jogo     (gnt_jogo),
    .gnt_aux      (gnt_aux),
    .valido_jogo  (valido_jogo),
    .valido_aux   (valido_aux),
    .q_leitura    (q_leitura),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  // Behavioural synchronous-read RAM.
  logic [3:0] ram [16];
  always @(posedge clock) begin
    if (mem_we) ram[mem_end] <= mem_d;
    mem_q <= ram[mem_end];
  end

  // Reference model: each accepted request is a scheduled transaction
  // (grant one cycle after the deciding edge, read data two cycles after that).
  int         cyc, free_at, acc_at, wr_at, esp;
  logic       acc_aux, acc_we, wr_pend;
  logic [3:0] rd_m, wr_end, wr_dat;
  logic [3:0] mem_m [16];
  logic       e_gj, e_ga, e_we, e_vj, e_va;
  logic [2:0] e_est;
  logic [3:0] e_end, e_d, e_q;

  task automatic model_reset();
    free_at = 0; acc_at = -10; esp = 0; wr_pend = 1'b0;
    acc_aux = 1'b0; acc_we = 1'b0; rd_m = 4'h0;
    e_gj = 0; e_ga = 0; e_we = 0; e_vj = 0; e_va = 0;
    e_est = 3'd0; e_end = 4'h0; e_d = 4'h0; e_q = 4'h0;
  endtask

  task automatic model_edge();
    bit idle, aux_ok, ganha_aux, ganha_jogo;
    cyc++;
    if (wr_pend && cyc == wr_at) begin
      mem_m[wr_end] = wr_dat;
      wr_pend = 1'b0;
    end
    idle       = (cyc >= free_at);
    aux_ok     = req_aux && !bloqueia_aux;
    ganha_aux  = idle && aux_ok && (esp == LIM || !req_jogo);
    ganha_jogo = idle && req_jogo && !ganha_aux;
    if (ganha_aux) begin
      acc_at = cyc; acc_aux = 1'b1; acc_we = 1'b0;
      e_end = end_aux; rd_m = mem_m[end_aux]; free_at = cyc + 3;
    end else if (ganha_jogo) begin
      acc_at = cyc; acc_aux = 1'b0; acc_we = we_jogo;
      e_end = end_jogo; e_d = dado_jogo; rd_m = mem_m[end_jogo];
      if (we_jogo) begin
        wr_pend = 1'b1; wr_at = cyc + 1; wr_end = end_jogo; wr_dat = dado_jogo;
        free_at = cyc + 2;
      end else begin
        free_at = cyc + 3;
      end
    end
    if (!req_aux || ganha_aux) esp = 0;
    else if (ganha_jogo && aux_ok && esp < LIM) esp++;
    e_gj = (acc_at == cyc) && !acc_aux;
    e_ga = (acc_at == cyc) && acc_aux;
    e_we = (acc_at == cyc) && !acc_aux && acc_we;
    if (acc_at == cyc) e_est = acc_aux ? 3'd2 : 3'd1;
    else if (acc_at == cyc - 1 && !acc_we) e_est = acc_aux ? 3'd4 : 3'd3;
    else e_est = 3'd0;
    e_vj = 1'b0; e_va = 1'b0;
    if (acc_at == cyc - 2 && !acc_we) begin
      if (acc_aux) e_va = 1'b1; else e_vj = 1'b1;
      e_q = rd_m;
    end
  endtask

  // One clock: model follows the active edge, outputs are inspected at the falling edge.
  task automatic cycle();
    @(posedge clock);
    if (reset) model_reset(); else model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_jogo = 0; we_jogo = 0; end_jogo = 0; dado_jogo = 0;
    req_aux = 0; end_aux = 0; bloqueia_aux = 0;
    for (int i = 0; i < 16; i++) begin ram[i] = 4'h0; mem_m[i] = 4'h0; end
    cyc = 0;
    model_reset();
    repeat (2) cycle();
    n_cmp++;
    if ({mem_we, gnt_jogo, gnt_aux, valido_jogo, valido_aux} !== 5'b0) begin
      n_err++; $display("FAIL reset_pulsos: got %b, want 00000",
                        {mem_we, gnt_jogo, gnt_aux, valido_jogo, valido_aux});
    end
    n_cmp++;
    if ({db_estado, q_leitura, mem_end, mem_d} !== 15'h0) begin
      n_err++; $display("FAIL reset_dados: estado=%0d q=%h end=%h d=%h, want all 0",
                        db_estado, q_leitura, mem_end, mem_d);
    end
    reset = 1'b0;
    cycle();
    n_cmp++;
    if (db_estado !== 3'd0) begin
      n_err++; $display("FAIL reset_ocioso: estado=%0d, want 0", db_estado);
    end
  endtask

  task automatic test_escrita_jogo();
    req_jogo = 1; we_jogo = 1; end_jogo = 4'h3; dado_jogo = 4'hA;
    cycle();
    n_cmp++;
    if ({gnt_jogo, mem_we, mem_end, mem_d} !== {1'b1, 1'b1, 4'h3, 4'hA}) begin
      n_err++; $display("FAIL escrita_k1: gnt=%b we=%b end=%h d=%h, want 1 1 3 a",
                        gnt_jogo, mem_we, mem_end, mem_d);
    end
    req_jogo = 0;
    cycle();
    n_cmp++;
    if ({gnt_jogo, mem_we, db_estado} !== 5'b0) begin
      n_err++; $display("FAIL escrita_k2: gnt=%b we=%b estado=%0d, want 0 0 0",
                        gnt_jogo, mem_we, db_estado);
    end
  endtask

  task automatic test_leitura_jogo();
    req_jogo = 1; we_jogo = 0; end_jogo = 4'h3;
    cycle();
    n_cmp++;
    if ({gnt_jogo, mem_we, valido_jogo} !== 3'b100) begin
      n_err++; $display("FAIL leitura_k1: gnt=%b we=%b val=%b, want 1 0 0",
                        gnt_jogo, mem_we, valido_jogo);
    end
    req_jogo = 0;
    cycle();
    n_cmp++;
    if ({gnt_jogo, valido_jogo, db_estado} !== {1'b0, 1'b0, 3'd3}) begin
      n_err++; $display("FAIL leitura_k2: gnt=%b val=%b estado=%0d, want 0 0 3",
                        gnt_jogo, valido_jogo, db_estado);
    end
    cycle();
    n_cmp++;
    if ({gnt_jogo, valido_jogo, q_leitura} !== {1'b0, 1'b1, 4'hA}) begin
      n_err++; $display("FAIL leitura_k3: gnt=%b val=%b q=%h, want 0 1 a",
                        gnt_jogo, valido_jogo, q_leitura);
    end
    cycle();
    n_cmp++;
    if ({valido_jogo, q_leitura} !== {1'b0, 4'hA}) begin
      n_err++; $display("FAIL leitura_hold: val=%b q=%h, want 0 a", valido_jogo, q_leitura);
    end
  endtask

  task automatic test_inanicao();
    int  gj;
    bit  viu;
    req_jogo = 1; we_jogo = 1; end_jogo = 4'h7;
    req_aux = 1; bloqueia_aux = 0; end_aux = 4'h2;
    for (int r = 0; r < 2; r++) begin
      gj = 0; viu = 0;
      for (int c = 0; c < 80 && !viu; c++) begin
        dado_jogo = 4'($urandom);
        cycle();
        if (gnt_jogo) gj++;
        if (gnt_aux) viu = 1;
      end
      n_cmp++;
      if (!viu || gj != LIM) begin
        n_err++; $display("FAIL inanicao_rodada%0d: %0d game grants before gnt_aux (gnt_aux seen=%0d), want %0d then gnt_aux",
                          r, gj, viu, LIM);
      end
    end
    req_jogo = 0; req_aux = 0;
    repeat (4) cycle();
  endtask

  task automatic test_bloqueio();
    int vistos;
    req_jogo = 0; req_aux = 1; bloqueia_aux = 1; end_aux = 4'hC;
    vistos = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      n_cmp++;
      if (gnt_aux !== 1'b0 || db_estado !== 3'd0) begin
        n_err++; vistos++;
        $display("FAIL bloqueio_ciclo%0d: gnt_aux=%b estado=%0d, want 0 0", c, gnt_aux, db_estado);
      end
    end
    bloqueia_aux = 0;
    cycle();
    n_cmp++;
    if ({gnt_aux, db_estado} !== {1'b1, 3'd2}) begin
      n_err++; $display("FAIL bloqueio_libera: gnt_aux=%b estado=%0d, want 1 2", gnt_aux, db_estado);
    end
    req_aux = 0;
    repeat (3) cycle();
  endtask

  task automatic test_reset_leitura();
    req_aux = 1; end_aux = 4'h3; req_jogo = 0; bloqueia_aux = 0;
    cycle();
    req_aux = 0;
    cycle();
    n_cmp++;
    if (db_estado !== 3'd4) begin
      n_err++; $display("FAIL rstleit_estado: estado=%0d, want 4", db_estado);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({db_estado, valido_aux} !== 4'b0) begin
      n_err++; $display("FAIL rstleit_async: estado=%0d val_aux=%b, want 0 0", db_estado, valido_aux);
    end
    cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      n_cmp++;
      if ({valido_aux, q_leitura} !== 5'b0) begin
        n_err++; $display("FAIL rstleit_pos%0d: val_aux=%b q=%h, want 0 0", c, valido_aux, q_leitura);
      end
    end
  endtask

  task automatic test_borda();
    req_jogo = 1; we_jogo = 1; end_jogo = 4'hF; dado_jogo = 4'h5;
    cycle();
    n_cmp++;
    if ({mem_we, mem_end, mem_d} !== {1'b1, 4'hF, 4'h5}) begin
      n_err++; $display("FAIL borda_escrita: we=%b end=%h d=%h, want 1 f 5", mem_we, mem_end, mem_d);
    end
    req_jogo = 0;
    cycle();
    req_aux = 1; end_aux = 4'hF;
    cycle();
    req_aux = 0;
    cycle();
    cycle();
    n_cmp++;
    if ({valido_aux, q_leitura} !== {1'b1, 4'h5}) begin
      n_err++; $display("FAIL borda_leitura: val_aux=%b q=%h, want 1 5", valido_aux, q_leitura);
    end
    cycle();
  endtask

  task automatic test_aleatorio();
    logic [19:0] obs, exp_v;
    for (int c = 0; c < 2000; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      req_jogo     = ($urandom_range(0, 99) < 55);
      we_jogo      = 1'($urandom_range(0, 1));
      end_jogo     = 4'($urandom);
      dado_jogo    = 4'($urandom);
      req_aux      = ($urandom_range(0, 99) < 50);
      bloqueia_aux = ($urandom_range(0, 99) < 20);
      end_aux      = 4'($urandom);
      cycle();
      obs   = {gnt_jogo, gnt_aux, mem_we, valido_jogo, valido_aux, db_estado,
               mem_end, mem_d, q_leitura};
      exp_v = {e_gj, e_ga, e_we, e_vj, e_va, e_est, e_end, e_d, e_q};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL aleatorio_ciclo%0d: outputs=%h, model=%h", c, obs, exp_v);
      end
    end
    reset = 0; req_jogo = 0; req_aux = 0; bloqueia_aux = 0;
    repeat (4) cycle();
  endtask

  initial begin
    test_reset();
    test_escrita_jogo();
    test_leitura_jogo();
    test_inanicao();
    test_bloqueio();
    test_reset_leitura();
    test_borda();
    test_aleatorio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
